// File: rtl/soma_pkg.sv
// soma_pkg: shared types and constants for the uc_soma adder sequencer.
//   state_e      FSM states IDLE/ALIGN/NORM/ROUND/RENORM/CAPT/OUT
//   sel_mux_e    normalizer input select (ALU, loopback, rounded)
//   sel_norm_e   normalizer action (pass, shift left, shift right)
//   MAX_NORM_DEF default normalization step limit (stored mantissa + 2)
package soma_pkg;
    localparam int MAX_NORM_DEF = 25;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        NORM,
        ROUND,
        RENORM,
        CAPT,
        OUT
    } state_e;

    typedef enum logic [1:0] {
        SEL_ALU  = 2'b00,
        SEL_LOOP = 2'b01,
        SEL_RND  = 2'b10
    } sel_mux_e;

    typedef enum logic [1:0] {
        NORM_PASS  = 2'b00,
        NORM_LEFT  = 2'b01,
        NORM_RIGHT = 2'b10
    } sel_norm_e;
endpackage

// File: rtl/uc_soma_hs.sv
// uc_soma_hs: operand and result holding registers for the adder sequencer.
//   clk, rst_n       clock, asynchronous active-low reset
//   load, a_in, b_in capture operand pair into a_q/b_q
//   cap, r_in        capture result into r_q and raise v_q
//   rel              consumer took the result, drop v_q
//   a_q, b_q         registered operands to datapath
//   r_q, v_q         registered result and its valid flag
module uc_soma_hs #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    input  logic         cap,
    input  logic [W-1:0] r_in,
    input  logic         rel,
    output logic [W-1:0] a_q,
    output logic [W-1:0] b_q,
    output logic [W-1:0] r_q,
    output logic         v_q
);
    logic [W-1:0] a_d, b_d, r_d;
    logic         v_d;

    always_comb begin
        a_d = load ? a_in : a_q;
        b_d = load ? b_in : b_q;
        r_d = cap ? r_in : r_q;
        v_d = cap ? 1'b1 : (rel ? 1'b0 : v_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            r_q <= '0;
            v_q <= 1'b0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            r_q <= r_d;
            v_q <= v_d;
        end
    end
endmodule

// File: rtl/uc_soma.sv
// uc_soma: sequencing/control unit for the single-precision adder datapath.
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready, in_A/B   operand handshake
//   float_A/B                   registered operands to datapath
//   diferenca_exp, antes_virgula, float_R   datapath feedback and result
//   sel_mux_normalizer, sel_normalizer      datapath control
//   out_valid/out_ready, result result handshake
//   busy                        high whenever the FSM is not idle
// Optional: define UC_SOMA_ZERO_DET_EN to force +0 when normalization hits MAX_NORM.
module uc_soma
    import soma_pkg::*;
#(
    parameter int N_float  = 32,
    parameter int N_exp    = 8,
    parameter int N_mant   = MAX_NORM_DEF - 2,
    parameter int MAX_NORM = N_mant + 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_float-1:0] in_A,
    input  logic [N_float-1:0] in_B,
    output logic [N_float-1:0] float_A,
    output logic [N_float-1:0] float_B,
    input  logic [N_exp-1:0]   diferenca_exp,
    input  logic [1:0]         antes_virgula,
    input  logic [N_float-1:0] float_R,
    output logic [1:0]         sel_mux_normalizer,
    output logic [1:0]         sel_normalizer,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_float-1:0] result,
    output logic               busy
);
    localparam int CW = $clog2(MAX_NORM + 1);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           lim_q, lim_d;
    logic           rdy_q, rdy_d;
    sel_mux_e       mux;
    sel_norm_e      nrm;
    logic           xfer;
    logic [N_float-1:0] cap_r;
    logic           unused_dexp;

    // Exponent difference is consumed by the datapath only.
    assign unused_dexp = ^diferenca_exp;

    assign xfer               = in_valid & rdy_q;
    assign in_ready           = rdy_q;
    assign busy               = state_q != IDLE;
    assign sel_mux_normalizer = mux;
    assign sel_normalizer     = nrm;

`ifdef UC_SOMA_ZERO_DET_EN
    // Exhausting the shift budget means the sum cancelled to zero.
    assign cap_r = lim_q ? '0 : float_R;
`else
    logic unused_lim;
    assign unused_lim = lim_q;
    assign cap_r      = float_R;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lim_d   = lim_q;
        mux     = SEL_ALU;
        nrm     = NORM_PASS;
        case (state_q)
            IDLE:   state_d = xfer ? ALIGN : IDLE;
            ALIGN: begin
                cnt_d   = '0;
                lim_d   = 1'b0;
                state_d = NORM;
            end
            NORM: begin
                // Only the first step reads the ALU; later ones feed back.
                mux = (cnt_q == '0) ? SEL_ALU : SEL_LOOP;
                if (cnt_q == CW'(MAX_NORM)) begin
                    lim_d   = 1'b1;
                    state_d = ROUND;
                end else if (antes_virgula[1]) begin
                    nrm   = NORM_RIGHT;
                    cnt_d = cnt_q + 1'b1;
                end else if (!antes_virgula[0]) begin
                    nrm   = NORM_LEFT;
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                mux     = SEL_RND;
                state_d = antes_virgula[1] ? RENORM : CAPT;
            end
            RENORM: begin
                mux     = SEL_LOOP;
                nrm     = NORM_RIGHT;
                state_d = CAPT;
            end
            CAPT:   state_d = OUT;
            OUT:    state_d = (out_valid & out_ready) ? IDLE : OUT;
            default: state_d = IDLE;
        endcase
        // Registered so in_ready stays low while reset is held.
        rdy_d = state_d == IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lim_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lim_q   <= lim_d;
            rdy_q   <= rdy_d;
        end
    end

    uc_soma_hs #(.W(N_float)) u_hs (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (xfer),
        .a_in  (in_A),
        .b_in  (in_B),
        .cap   (state_q == CAPT),
        .r_in  (cap_r),
        .rel   (out_valid & out_ready),
        .a_q   (float_A),
        .b_q   (float_B),
        .r_q   (result),
        .v_q   (out_valid)
    );
endmodule

// File: tb/tb_uc_soma.sv
// tb_uc_soma: randomized self-checking bench for uc_soma with an abstract datapath stand-in.
module tb_uc_soma;
    localparam int MAXN = 25;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_A = '0, in_B = '0;
    logic [31:0] float_A, float_B, float_R, result;
    logic [7:0]  diferenca_exp;
    logic [1:0]  antes_virgula, sel_mux_normalizer, sel_normalizer;
    logic        out_valid, out_ready = 1'b0, busy;

    // Datapath stand-in: pos is the leading-one position relative to the
    // binary point (>0 overflowed, 0 normalized, <0 too small).
    int          pos = 0;
    logic        rc = 1'b0;
    logic [31:0] fr = '0;
    logic [7:0]  dexp = '0;

    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    assign antes_virgula = (sel_mux_normalizer == 2'b10) ? (rc ? 2'b10 : 2'b01) :
                           (pos > 1) ? 2'b11 : (pos == 1) ? 2'b10 :
                           (pos == 0) ? 2'b01 : 2'b00;
    assign float_R       = fr;
    assign diferenca_exp = dexp;

    uc_soma dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_A(in_A), .in_B(in_B),
        .float_A(float_A), .float_B(float_B),
        .diferenca_exp(diferenca_exp), .antes_virgula(antes_virgula), .float_R(float_R),
        .sel_mux_normalizer(sel_mux_normalizer), .sel_normalizer(sel_normalizer),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input int p,
                           input logic r, input logic [31:0] f, input int hold);
        int mag, shifts, n, left, right, rnd;
        logic lim;
        logic [31:0] er;
        logic [1:0] sn;
        mag    = (p < 0) ? -p : p;
        shifts = (mag < MAXN) ? mag : MAXN;
        lim    = mag >= MAXN;
        er     = f;
`ifdef UC_SOMA_ZERO_DET_EN
        if (lim) er = '0;
`endif
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_idle", in_ready, 1);
        pos = p; rc = r; fr = f; dexp = 8'($urandom);
        in_A = a; in_B = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_A = $urandom; in_B = $urandom;
        n = 0; left = 0; right = 0; rnd = 0;
        while (n < 200) begin
            @(negedge clk);
            if (out_valid) break;
            sn = sel_normalizer;
            if (sn == 2'b01) left++;
            if (sn == 2'b10) right++;
            if (sel_mux_normalizer == 2'b10) rnd++;
            @(posedge clk);
            #1;
            n++;
            if (sn == 2'b01) pos++;
            else if (sn == 2'b10) pos--;
        end
        check("latency", n, 4 + shifts + r);
        check("result", result, er);
        check("float_A", float_A, a);
        check("float_B", float_B, b);
        check("left_shifts", left, (p < 0) ? shifts : 0);
        check("right_shifts", right, ((p > 0) ? shifts : 0) + r);
        check("round_cycles", rnd, 1);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; in_A = $urandom; in_B = $urandom;
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_result", result, er);
            check("hold_in_ready", in_ready, 0);
            check("hold_float_A", float_A, a);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("valid_dropped", out_valid, 0);
        check("in_ready_back", in_ready, 1);
        check("busy_cleared", busy, 0);
        check("float_B_stable", float_B, b);
    endtask

    initial begin
        #23;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_float_A", float_A, 0);
        check("rst_result", result, 0);
        check("rst_sel_mux", sel_mux_normalizer, 0);
        check("rst_sel_norm", sel_normalizer, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_txn(32'h3F800000, 32'h3F800000, 1, 1'b0, 32'h40000000, 10);
        run_txn(32'h3FC00000, 32'hBF800000, -1, 1'b0, 32'h3F000000, 1);
        run_txn(32'h3F800000, 32'hBF800000, -1000, 1'b0, 32'h0BAD0000, 0);
        run_txn(32'h3FFFFFFF, 32'h33800000, 0, 1'b1, 32'h40000000, 2);
        run_txn(32'h12345678, 32'h9ABCDEF0, -25, 1'b0, 32'h5A5A5A5A, 0);
        run_txn(32'h11111111, 32'h22222222, -24, 1'b1, 32'h3C3C3C3C, 0);

        for (int k = 0; k < 24; k++)
            run_txn($urandom, $urandom, int'($urandom_range(0, 32)) - 30,
                    1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 3)));

        @(negedge clk);
        pos = -20; rc = 1'b0; fr = 32'hDEADBEEF;
        in_A = 32'h3F800000; in_B = 32'hBF800000; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_float_A", float_A, 0);
        check("mid_rst_float_B", float_B, 0);
        check("mid_rst_sel_norm", sel_normalizer, 0);
        check("mid_rst_sel_mux", sel_mux_normalizer, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(32'h3F800000, 32'h3F800000, 1, 1'b0, 32'h40000000, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uc_soma.md
Name: uc_soma

Overview:
- Sequencing/control unit for the single-precision adder datapath; sits directly upstream of it and drives its control inputs.
- Accepts operand pairs through a valid/ready handshake and holds them in registers that feed the datapath float_A/float_B.
- Walks the datapath through align, iterative normalize, round and renormalize, using diferenca_exp and antes_virgula as feedback.
- Captures float_R into a result register and presents it through a valid/ready output handshake.

Parameters:
- N_float, 32, float width
- N_exp, 8, exponent width
- N_mant, 23, stored mantissa width
- MAX_NORM, 25, normalization step limit (N_mant+2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- in_A  in  N_float  operand A
- in_B  in  N_float  operand B
- float_A  out  N_float  registered operand A to datapath
- float_B  out  N_float  registered operand B to datapath
- diferenca_exp  in  N_exp  datapath exponent difference (two's complement)
- antes_virgula  in  2  datapath bits left of binary point at normalizer input
- float_R  in  N_float  datapath result
- sel_mux_normalizer  out  2  00 BigAlu, 01 normalizer loopback, 10 rounded
- sel_normalizer  out  2  00 pass, 01 shift left/exp-1, 10 shift right/exp+1
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  N_float  registered sum
- busy  out  1  high in every state except IDLE

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0, FSM in IDLE, step counter 0. in_ready rises the first cycle after reset release.
- in_ready = (state==IDLE). Transfer on in_valid&in_ready: in_A/in_B are latched into float_A/float_B. FSM goes to ALIGN.
- ALIGN, 1 cycle: sel_mux=00, sel_norm=00. The datapath settles, with diferenca_exp valid. Go to NORM with cnt=0.
- NORM, one step per cycle:
  - First cycle sel_mux=00; later cycles sel_mux=01.
  - antes_virgula 1x: sel_norm=10, stay.
  - antes_virgula 00: sel_norm=01, stay.
  - antes_virgula 01: sel_norm=00, go to ROUND.
  - cnt increments on every shift. At cnt==MAX_NORM, exit to ROUND regardless and set internal flag lim.
- ROUND, 1 cycle: sel_mux=10, sel_norm=00.
  - antes_virgula 1x (round carry-out): go to RENORM.
  - Otherwise: go to CAPT.
- RENORM, 1 cycle: sel_mux=01, sel_norm=10. Go to CAPT.
- CAPT: result<=float_R, out_valid<=1, go to OUT.
- OUT: hold result and out_valid until out_ready. On out_valid&out_ready: clear out_valid, go to IDLE. in_ready rises the next cycle; there is no back-to-back overlap.
- Latency: in-transfer to out_valid = 4 + shift count (+1 if RENORM) cycles.
- Inputs in_A/in_B are ignored while busy. float_A/float_B stay stable from capture until the next transfer.
- Reset mid-operation: immediate return to reset values. The pending result is discarded.
- diferenca_exp is observed only; it does not affect sequencing.

Optional Feature:
- UC_SOMA_ZERO_DET_EN
- Defined: if lim is set at CAPT, result<=32'h00000000 (+0) instead of float_R.
- Undefined: lim has no effect, and float_R is captured as-is.

Decomposition:
- Package soma_pkg:
  - state enum IDLE/ALIGN/NORM/ROUND/RENORM/CAPT/OUT
  - sel_mux encodings SEL_ALU=00, SEL_LOOP=01, SEL_RND=10
  - sel_norm encodings NORM_PASS=00, NORM_LEFT=01, NORM_RIGHT=10
  - MAX_NORM default
- Natural sub-module: uc_soma_hs, an operand/result handshake register pair. The FSM stays in uc_soma.

Test Plan:
- 3F800000 + 3F800000: single 1x step, then sel_norm=10 once → result 40000000; latency 5 cycles.
- 3FC00000 + BF800000: one left shift (sel_norm=01) → result 3F000000.
- 3F800000 + BF800000: MAX_NORM=25 left shifts then exit. With UC_SOMA_ZERO_DET_EN, result 00000000; without it, result equals float_R.
- out_ready held low 10 cycles after out_valid: result and out_valid stable, in_ready=0, and in_valid pulses ignored.
- rst_n asserted during NORM: outputs zero asynchronously. After release, a new transfer of 3F800000+3F800000 yields 40000000.
- Round carry case 3FFFFFFF + 33800000: ROUND sees 1x → RENORM one cycle → result 40000000.
